// File: rtl/hq2x_decim_if.sv
`default_nettype none
// ============================================================================
//  Module      : hq2x_decim_if
//  Description : Pixel-stream bundle for the 2:1 box-filter downscaler.
//                Carries the input-side pixel stream with its line/frame
//                markers and the output-side read controls and pixel.
//                master = video source / output timing generator
//                slave  = hq2x_decim
//  Signals     : ce_in, inputpixel, reset_line, reset_frame  (source -> dut)
//                ce_out, hblank                               (timing -> dut)
//                line_ready, outpixel                         (dut -> sink)
//  Revision    : 1.0  initial release
// ============================================================================
interface hq2x_decim_if #(
    parameter int HALF_DEPTH = 0
);
    localparam int c_DWIDTH = (HALF_DEPTH != 0) ? 11 : 23;

    logic                ce_in;
    logic [c_DWIDTH:0]   inputpixel;
    logic                reset_line;
    logic                reset_frame;
    logic                line_ready;
    logic                ce_out;
    logic                hblank;
    logic [c_DWIDTH:0]   outpixel;

    modport master (
        output ce_in,
        output inputpixel,
        output reset_line,
        output reset_frame,
        output ce_out,
        output hblank,
        input  line_ready,
        input  outpixel
    );

    modport slave (
        input  ce_in,
        input  inputpixel,
        input  reset_line,
        input  reset_frame,
        input  ce_out,
        input  hblank,
        output line_ready,
        output outpixel
    );
endinterface
`default_nettype wire

// File: rtl/hq2x_decim.sv
`default_nettype none
// ============================================================================
//  Module      : hq2x_decim
//  Description : 2:1 box-filter downscaler. Each 2x2 block of the incoming
//                double-resolution stream is averaged into one output pixel.
//                Horizontal pairs of an even line are summed into a sum RAM;
//                on the following odd line each horizontal pair sum is added
//                to the stored sum, rounded and divided by four, and written
//                into the write bank of a double-buffered output line store.
//                The other bank is read out on ce_out.
//  Ports       : clk         sole clock
//                reset_n     asynchronous active-low reset
//                bus.ce_in / inputpixel / reset_line / reset_frame
//                            input pixel stream and blanking markers
//                bus.line_ready  one-clk pulse, output line completed
//                bus.ce_out / hblank  output read timing
//                bus.outpixel    registered output pixel
//  Revision    : 1.0  initial release
// ============================================================================
module hq2x_decim #(
    parameter int LENGTH     = 1024,
    parameter int HALF_DEPTH = 0
) (
    input  wire          clk,
    input  wire          reset_n,
    hq2x_decim_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_CW     = (HALF_DEPTH != 0) ? 4 : 8;     // channel width
    localparam int c_DWIDTH = 3 * c_CW - 1;                   // pixel MSB index
    localparam int AWIDTH   = $clog2(LENGTH) - 1;             // address MSB index
    localparam int c_AW     = AWIDTH + 1;                     // address bits
    localparam int c_XW     = c_AW + 2;                       // input x counter bits (0..2*LENGTH)
    localparam int c_PW     = c_CW + 1;                       // pair-sum channel width
    localparam int c_SW     = 3 * c_PW;                       // sum RAM word width

    localparam logic [c_XW-1:0] c_X_MAX  = c_XW'(2 * LENGTH);
    localparam logic [c_AW-1:0] c_RD_MAX = c_AW'(LENGTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                 r_rl_d;        // reset_line as last sampled on ce_in
    logic [c_XW-1:0]      r_x_in;
    logic                 r_par;         // 0 = even line, 1 = odd line
    logic                 r_wsel;        // output bank currently being written
    logic [c_AW:0]        r_even_cnt;    // pair count of the last even line
    logic                 r_have_even;   // an even line precedes the current odd line
    logic [c_DWIDTH:0]    r_hold;        // first pixel of the current pair
    logic                 r_line_ready;
    logic [c_SW-1:0]      r_sum_q;       // stored even-line pair sum for this pair

    logic [c_AW-1:0]      r_read_x;
    logic [c_DWIDTH:0]    r_rd_q;        // output store read data
    logic [c_DWIDTH:0]    r_outpixel;

    logic [c_SW-1:0]      r_sum_ram [LENGTH];
    logic [c_DWIDTH:0]    r_out_ram [2*LENGTH];  // {bank, index}

    // ------------------------------------------------------------------------
    // Input-side decode
    // ------------------------------------------------------------------------
    logic                 w_fall;
    logic                 w_accept;
    logic [c_AW-1:0]      w_idx;
    logic                 w_use_sum;
    logic [c_SW-1:0]      w_pair;
    logic [c_DWIDTH:0]    w_res;

    // A line starts on the first ce_in sample with reset_line low after a
    // high one. That sample itself carries no pixel, so accepts require the
    // previous sample to be low as well.
    assign w_fall   = r_rl_d & ~bus.reset_line;
    assign w_accept = ~r_rl_d & ~bus.reset_line & (r_x_in < c_X_MAX);
    assign w_idx    = r_x_in[c_AW:1];

    // Only blend with the stored sum where the preceding even line actually
    // reached this pair; otherwise duplicate the odd line vertically.
    assign w_use_sum = r_have_even & ({1'b0, w_idx} < r_even_cnt);

    for (genvar c = 0; c < 3; c++) begin : g_chan
        logic [c_PW-1:0] w_p;
        logic [c_PW-1:0] w_s;
        logic [c_CW+1:0] w_sum4;
        logic [c_CW+1:0] w_sum2;
        logic            w_unused_lsbs;

        assign w_p    = {1'b0, r_hold[c*c_CW +: c_CW]} + {1'b0, bus.inputpixel[c*c_CW +: c_CW]};
        assign w_s    = r_sum_q[c*c_PW +: c_PW];
        // Rounded averages: (p+s+2)>>2 for four pixels, (p+1)>>1 for two.
        assign w_sum4 = {1'b0, w_p} + {1'b0, w_s} + (c_CW+2)'(2);
        assign w_sum2 = {1'b0, w_p} + (c_CW+2)'(1);

        assign w_pair[c*c_PW +: c_PW] = w_p;
        assign w_res[c*c_CW +: c_CW]  = w_use_sum ? w_sum4[c_CW+1:2] : w_sum2[c_CW:1];

        // Bits discarded by the divide, plus the MSB of the 2-pixel sum which
        // is always zero because p+1 never exceeds 2^(CW+1)-1.
        assign w_unused_lsbs = ^{w_sum4[1:0], w_sum2[0], w_sum2[c_CW+1]};
    end

    // ------------------------------------------------------------------------
    // Input-side control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rl_d       <= 1'b0;
            r_x_in       <= '0;
            r_par        <= 1'b0;
            r_wsel       <= 1'b0;
            r_even_cnt   <= '0;
            r_have_even  <= 1'b0;
            r_hold       <= '0;
            r_line_ready <= 1'b0;
        end else begin
            r_line_ready <= 1'b0;
            if (bus.ce_in) begin
                r_rl_d <= bus.reset_line;
                if (w_fall) begin
                    r_x_in <= '0;
                    if (bus.reset_frame) begin
                        r_par       <= 1'b0;
                        r_have_even <= 1'b0;
                    end else begin
                        r_par       <= ~r_par;
                        // The new line is odd exactly when the ended one was even.
                        r_have_even <= ~r_par;
                    end
                    // Ending an odd line completes an output line: swap banks.
                    if (r_par) begin
                        r_wsel       <= ~r_wsel;
                        r_line_ready <= 1'b1;
                    end
                    // Next line is even: forget the previous even line's width.
                    if (bus.reset_frame || r_par) begin
                        r_even_cnt <= '0;
                    end
                end else if (w_accept) begin
                    r_x_in <= r_x_in + 1'b1;
                    if (!r_x_in[0]) begin
                        r_hold <= bus.inputpixel;
                    end else if (!r_par) begin
                        r_even_cnt <= {1'b0, w_idx} + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line stores (not reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.ce_in && w_accept) begin
            if (!r_x_in[0]) begin
                // Fetch the even-line sum now; it is consumed on the odd pixel.
                r_sum_q <= r_sum_ram[w_idx];
            end else if (!r_par) begin
                r_sum_ram[w_idx] <= w_pair;
            end else begin
                r_out_ram[{r_wsel, w_idx}] <= w_res;
            end
        end
        // Readout bank follows wsel, so a bank swap is visible from the next clk.
        r_rd_q <= r_out_ram[{~r_wsel, r_read_x}];
    end

    // ------------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read_x   <= '0;
            r_outpixel <= '0;
        end else if (bus.ce_out) begin
            if (bus.hblank) begin
                r_read_x <= '0;
            end else if (r_read_x != c_RD_MAX) begin
                r_read_x <= r_read_x + 1'b1;
            end
            r_outpixel <= r_rd_q;
        end
    end

    assign bus.outpixel   = r_outpixel;
    assign bus.line_ready = r_line_ready;

endmodule
`default_nettype wire

// File: tb/tb_hq2x_decim.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hq2x_decim
//  Description : Directed bench for hq2x_decim. Two instances with LENGTH=8:
//                full-depth (24-bit pixels) and half-depth (12-bit pixels).
//                Expected output words are queued when a readout is issued
//                and compared by an independent monitor on each sampled
//                ce_out.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hq2x_decim;

    localparam int LEN = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hq2x_decim_if #(.HALF_DEPTH(0)) fif ();
    hq2x_decim_if #(.HALF_DEPTH(1)) hif ();

    hq2x_decim #(.LENGTH(LEN), .HALF_DEPTH(0)) dut_f (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (fif.slave)
    );

    hq2x_decim #(.LENGTH(LEN), .HALF_DEPTH(1)) dut_h (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (hif.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          lr_f   = 0;
    int          lr_h   = 0;
    logic        chk_f  = 1'b0;
    logic        chk_h  = 1'b0;
    logic        fire_f = 1'b0;
    logic        fire_h = 1'b0;
    logic [23:0] exp_f [$];
    logic [23:0] exp_h [$];
    logic [23:0] pix_q [$];
    logic [23:0] exp_words [LEN];
    logic [23:0] e_f;
    logic [23:0] e_h;

    // ------------------------------------------------------------------------
    // Monitor: a compare is due on the negedge after a ce_out edge that the
    // stimulus marked for checking.
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        fire_f <= fif.ce_out & chk_f;
        fire_h <= hif.ce_out & chk_h;
    end

    always @(negedge clk) begin
        if (fire_f) begin
            checks++;
            if (exp_f.size() == 0) begin
                errors++;
                $display("FAIL word_full: got %h, nothing expected", fif.outpixel);
            end else begin
                e_f = exp_f.pop_front();
                if (fif.outpixel !== e_f) begin
                    errors++;
                    $display("FAIL word_full: got %h, required %h", fif.outpixel, e_f);
                end
            end
        end
        if (fire_h) begin
            checks++;
            if (exp_h.size() == 0) begin
                errors++;
                $display("FAIL word_half: got %h, nothing expected", hif.outpixel);
            end else begin
                e_h = exp_h.pop_front();
                if (hif.outpixel !== e_h[11:0]) begin
                    errors++;
                    $display("FAIL word_half: got %h, required %h", hif.outpixel, e_h[11:0]);
                end
            end
        end
        if (fif.line_ready === 1'b1) lr_f++;
        if (hif.line_ready === 1'b1) lr_h++;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ce_in sample followed by an idle clk.
    task automatic in_cyc(input bit half, input logic rl, input logic rf, input logic [23:0] pix);
        if (half) begin
            hif.ce_in = 1'b1; hif.reset_line = rl; hif.reset_frame = rf; hif.inputpixel = pix[11:0];
        end else begin
            fif.ce_in = 1'b1; fif.reset_line = rl; fif.reset_frame = rf; fif.inputpixel = pix;
        end
        tick();
        if (half) hif.ce_in = 1'b0;
        else      fif.ce_in = 1'b0;
        tick();
    endtask

    // Blank then the reset_line fall that starts a line.
    task automatic start_line(input bit half, input logic rf);
        for (int i = 0; i < 2; i++) in_cyc(half, 1'b1, rf, 24'h0);
        in_cyc(half, 1'b0, rf, 24'h0);
    endtask

    task automatic send_pixels(input bit half);
        foreach (pix_q[i]) in_cyc(half, 1'b0, 1'b0, pix_q[i]);
        pix_q.delete();
    endtask

    // n_ce ce_outs with hblank low; ce_out number n shows word n-2 (clamped).
    task automatic readout(input bit half, input int n_ce, input int first_n);
        for (int k = 0; k < 3; k++) tick();
        for (int n = 1; n <= n_ce; n++) begin
            int w;
            w = n - 2;
            if (w < 0) w = 0;
            if (w > LEN - 1) w = LEN - 1;
            if (half) begin
                hif.hblank = 1'b0;
                chk_h = (n >= first_n);
                if (chk_h) exp_h.push_back(exp_words[w]);
            end else begin
                fif.hblank = 1'b0;
                chk_f = (n >= first_n);
                if (chk_f) exp_f.push_back(exp_words[w]);
            end
            tick();
        end
        fif.hblank = 1'b1; hif.hblank = 1'b1;
        chk_f = 1'b0; chk_h = 1'b0;
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0] b;
        fif.ce_in = 1'b0; fif.inputpixel = '0; fif.reset_line = 1'b1; fif.reset_frame = 1'b0;
        fif.ce_out = 1'b1; fif.hblank = 1'b1;
        hif.ce_in = 1'b0; hif.inputpixel = '0; hif.reset_line = 1'b1; hif.reset_frame = 1'b0;
        hif.ce_out = 1'b1; hif.hblank = 1'b1;

        repeat (3) tick();
        check("reset_outpixel", 32'(fif.outpixel), 32'h0);
        check("reset_line_ready", 32'(fif.line_ready), 32'h0);
        reset_n = 1'b1;
        tick();

        // Basic 2x2 average
        start_line(0, 1'b1);
        pix_q = '{24'h102030, 24'h102032}; send_pixels(0);
        start_line(0, 1'b0);
        pix_q = '{24'h102030, 24'h10203A}; send_pixels(0);
        start_line(0, 1'b0);
        check("line_ready_basic", 32'(lr_f), 32'd1);
        exp_words[0] = 24'h102033;
        readout(0, 2, 2);

        // Saturation / rounding
        pix_q = '{24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'h000001, 24'h000000, 24'h000000};
        send_pixels(0);
        start_line(0, 1'b0);
        pix_q = '{24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'h000001, 24'h000000, 24'h000002};
        send_pixels(0);
        start_line(0, 1'b0);
        check("line_ready_sat", 32'(lr_f), 32'd2);
        exp_words[0] = 24'hFFFFFF; exp_words[1] = 24'h000001; exp_words[2] = 24'h000001;
        readout(0, 4, 2);

        // Short even line: second pair duplicates vertically
        pix_q = '{24'h202020, 24'h404040}; send_pixels(0);
        start_line(0, 1'b0);
        pix_q = '{24'h101010, 24'h303030, 24'h050505, 24'h060606}; send_pixels(0);
        start_line(0, 1'b0);
        check("line_ready_short", 32'(lr_f), 32'd3);
        exp_words[0] = 24'h282828; exp_words[1] = 24'h060606;
        readout(0, 3, 2);

        // Overlong lines (2*LEN+3 pixels); excess pixels must not wrap onto word 0
        for (int j = 0; j < 2*LEN; j++) begin b = 8'(j); pix_q.push_back({b, b, b}); end
        for (int j = 0; j < 3; j++) pix_q.push_back(24'hFFFFFF);
        send_pixels(0);
        start_line(0, 1'b0);
        for (int j = 0; j < 2*LEN; j++) begin b = 8'(j); pix_q.push_back({b, b, b}); end
        for (int j = 0; j < 3; j++) pix_q.push_back(24'hFFFFFF);
        send_pixels(0);
        start_line(0, 1'b0);
        check("line_ready_long", 32'(lr_f), 32'd4);
        for (int k = 0; k < LEN; k++) begin b = 8'(2*k + 1); exp_words[k] = {b, b, b}; end
        readout(0, 12, 1);

        // Odd pixel count: trailing pixel leaves word 1 (from the short-line test) intact
        pix_q = '{24'h111111, 24'h333333, 24'h777777}; send_pixels(0);
        start_line(0, 1'b0);
        pix_q = '{24'h111111, 24'h333333, 24'hEEEEEE}; send_pixels(0);
        start_line(0, 1'b0);
        check("line_ready_oddcnt", 32'(lr_f), 32'd5);
        exp_words[0] = 24'h222222; exp_words[1] = 24'h060606;
        readout(0, 3, 2);

        // Reset in the middle of an odd line
        pix_q = '{24'h050505, 24'h050505}; send_pixels(0);
        start_line(0, 1'b0);
        pix_q = '{24'h090909}; send_pixels(0);
        reset_n = 1'b0;
        tick();
        check("midreset_outpixel", 32'(fif.outpixel), 32'h0);
        check("midreset_line_ready", 32'(fif.line_ready), 32'h0);
        tick();
        check("midreset_outpixel2", 32'(fif.outpixel), 32'h0);
        reset_n = 1'b1;
        tick();
        start_line(0, 1'b1);
        pix_q = '{24'h404040, 24'h404040, 24'h0A0B0C, 24'h0C0B0A}; send_pixels(0);
        start_line(0, 1'b0);
        pix_q = '{24'h404040, 24'h404040, 24'h0A0B0C, 24'h0C0B0A}; send_pixels(0);
        start_line(0, 1'b0);
        check("line_ready_after_reset", 32'(lr_f), 32'd6);
        exp_words[0] = 24'h404040; exp_words[1] = 24'h0B0B0B;
        readout(0, 3, 2);

        // Half-depth instance
        start_line(1, 1'b1);
        pix_q = '{24'h000123, 24'h000125}; send_pixels(1);
        start_line(1, 1'b0);
        pix_q = '{24'h000123, 24'h00012B}; send_pixels(1);
        start_line(1, 1'b0);
        check("line_ready_half", 32'(lr_h), 32'd1);
        exp_words[0] = 24'h000126;
        readout(1, 2, 2);

        repeat (3) tick();
        check("queue_full_drained", 32'(exp_f.size()), 32'd0);
        check("queue_half_drained", 32'(exp_h.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
